// File: rtl/dbus_arbiter.sv
// dbus_arbiter: sequences the shared external data bus between the CPU and the DMA requester,
// with round-robin grant and memory/I/O strobes that have programmable wait states.
module dbus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          c_req,
    input  logic          c_wr,
    input  logic          c_io,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_done,
    input  logic          k_req,
    input  logic          k_wr,
    input  logic          k_io,
    input  logic [AW-1:0] k_addr,
    input  logic [DW-1:0] k_wdata,
    output logic [DW-1:0] k_rdata,
    output logic          k_done,
    output logic [AW-1:0] Mem_addr,
    output logic [DW-1:0] bus_wdata,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_rdata,
    output logic          dcs_,
    output logic          drd_,
    output logic          dwr_,
    output logic          IOcs_,
    output logic          IOrd_,
    output logic          IOwr_,
    output logic          gnt,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic          r_sel, r_last, r_wr, r_io;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          w_any, w_pick, w_act, w_stb, w_rec;

    // on contention the requester not served last wins; r_last resets to DMA so CPU goes first
    assign w_any     = c_req | k_req;
    assign w_pick    = (c_req & k_req) ? ~r_last : k_req;
    assign Mem_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign gnt       = r_sel;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_wr    <= 1'b0;
            r_io    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_sel   <= w_pick;
                r_wr    <= w_pick ? k_wr : c_wr;
                r_io    <= w_pick ? k_io : c_io;
                r_addr  <= w_pick ? k_addr : c_addr;
                r_wdata <= w_pick ? k_wdata : c_wdata;
            end
            if (r_state == SETUP)
                r_cnt <= 4'(WAIT_STATES);
            else if (r_state == STROBE)
                r_cnt <= r_cnt - 4'd1;
            if (r_state == RECOVER)
                r_last <= r_sel;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? SETUP : IDLE;
            SETUP:   w_next = STROBE;
            STROBE:  w_next = (r_cnt == 4'd0) ? RECOVER : STROBE;
            RECOVER: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_act = (r_state == SETUP) || (r_state == STROBE);
        w_stb = (r_state == STROBE);
        w_rec = (r_state == RECOVER);
    end

    // bus pins follow the state register by one cycle so every output comes straight from a flop
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dcs_    <= 1'b1;
            drd_    <= 1'b1;
            dwr_    <= 1'b1;
            IOcs_   <= 1'b1;
            IOrd_   <= 1'b1;
            IOwr_   <= 1'b1;
            bus_oe  <= 1'b0;
            busy    <= 1'b0;
            c_done  <= 1'b0;
            k_done  <= 1'b0;
            c_rdata <= '0;
            k_rdata <= '0;
        end else begin
            dcs_   <= ~(w_act & ~r_io);
            drd_   <= ~(w_stb & ~r_io & ~r_wr);
            dwr_   <= ~(w_stb & ~r_io & r_wr);
            IOcs_  <= ~(w_act & r_io);
            IOrd_  <= ~(w_stb & r_io & ~r_wr);
            IOwr_  <= ~(w_stb & r_io & r_wr);
            bus_oe <= w_act & r_wr;
            busy   <= r_state != IDLE;
            c_done <= w_rec & ~r_sel;
            k_done <= w_rec & r_sel;
            if (w_rec & ~r_wr & ~r_sel)
                c_rdata <= bus_rdata;
            if (w_rec & ~r_wr & r_sel)
                k_rdata <= bus_rdata;
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: cycle-trace vectors for the WAIT_STATES=1 arbiter plus hand sequences for
// round-robin, reset abort and a WAIT_STATES=0 instance.
module tb_dbus_arbiter;
    localparam logic [31:0] CA = 32'h0000_0010, CW = 32'hC0DE_0001;
    localparam logic [31:0] KA = 32'h0000_0400, KW = 32'h1234_5678;
    localparam logic [31:0] DB = 32'hDEAD_BEEF, R1 = 32'h1111_1111, R2 = 32'h2222_2222;
    localparam logic [5:0]  I = 6'b111111, MS = 6'b011111, MR = 6'b001111;
    localparam logic [5:0]  IS = 6'b111011, IW = 6'b111010;

    typedef struct {
        logic         cr, kr;
        logic [3:0]   ctl;
        logic [31:0]  rd;
        logic [138:0] exp;
    } vec_t;

    logic        Clk = 1'b0, Reset = 1'b0;
    logic        c_req = 0, c_wr = 0, c_io = 0, k_req = 0, k_wr = 0, k_io = 0;
    logic [31:0] c_addr = CA, c_wdata = CW, k_addr = KA, k_wdata = KW, bus_rdata = '0;
    logic [31:0] c_rdata, k_rdata, Mem_addr, bus_wdata;
    logic        c_done, k_done, bus_oe, dcs_, drd_, dwr_, IOcs_, IOrd_, IOwr_, gnt, busy;
    logic        z_req = 0;
    logic [31:0] z_rd = '0, z_rdata, z_krd, z_addr, z_wd;
    logic        z_done, z_kd, z_oe, z_dcs, z_drd, z_dwr, z_ics, z_ird, z_iwr, z_gnt, z_busy;
    int          tests = 0, fails = 0;
    vec_t        vq[$];

    always #5 Clk = ~Clk;

    dbus_arbiter #(.WAIT_STATES(1), .AW(32), .DW(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_wr(c_wr), .c_io(c_io), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_done(c_done),
        .k_req(k_req), .k_wr(k_wr), .k_io(k_io), .k_addr(k_addr), .k_wdata(k_wdata),
        .k_rdata(k_rdata), .k_done(k_done),
        .Mem_addr(Mem_addr), .bus_wdata(bus_wdata), .bus_oe(bus_oe), .bus_rdata(bus_rdata),
        .dcs_(dcs_), .drd_(drd_), .dwr_(dwr_), .IOcs_(IOcs_), .IOrd_(IOrd_), .IOwr_(IOwr_),
        .gnt(gnt), .busy(busy)
    );

    dbus_arbiter #(.WAIT_STATES(0), .AW(32), .DW(32)) dut0 (
        .Clk(Clk), .Reset(Reset),
        .c_req(z_req), .c_wr(1'b0), .c_io(1'b0), .c_addr(32'h40), .c_wdata(32'h0),
        .c_rdata(z_rdata), .c_done(z_done),
        .k_req(1'b0), .k_wr(1'b0), .k_io(1'b0), .k_addr(32'h0), .k_wdata(32'h0),
        .k_rdata(z_krd), .k_done(z_kd),
        .Mem_addr(z_addr), .bus_wdata(z_wd), .bus_oe(z_oe), .bus_rdata(z_rd),
        .dcs_(z_dcs), .drd_(z_drd), .dwr_(z_dwr), .IOcs_(z_ics), .IOrd_(z_ird), .IOwr_(z_iwr),
        .gnt(z_gnt), .busy(z_busy)
    );

    task automatic check(input string name, input logic [138:0] act, input logic [138:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ctl = {c_wr, c_io, k_wr, k_io}; f = {bus_oe, c_done, k_done, busy, gnt}
    task automatic add(input logic cr, input logic kr, input logic [3:0] ctl, input logic [31:0] rd,
                       input logic [5:0] stb, input logic [4:0] f, input logic [31:0] a,
                       input logic [31:0] w, input logic [31:0] crd, input logic [31:0] krd);
        vec_t v;
        v.cr  = cr;
        v.kr  = kr;
        v.ctl = ctl;
        v.rd  = rd;
        v.exp = {stb, f, a, w, crd, krd};
        vq.push_back(v);
    endtask

    function automatic logic [138:0] obs();
        return {dcs_, drd_, dwr_, IOcs_, IOrd_, IOwr_, bus_oe, c_done, k_done, busy, gnt,
                Mem_addr, bus_wdata, c_rdata, k_rdata};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, nrd, ncs;
        logic saw, b;
        // CPU memory read of 0xDEADBEEF
        add(1, 0, 4'b0011, DB, I,  5'b00000, CA, CW, 0, 0);
        add(1, 0, 4'b0011, DB, MS, 5'b00010, CA, CW, 0, 0);
        add(1, 0, 4'b0011, DB, MR, 5'b00010, CA, CW, 0, 0);
        add(1, 0, 4'b0011, DB, MR, 5'b00010, CA, CW, 0, 0);
        add(1, 0, 4'b0011, DB, I,  5'b01010, CA, CW, DB, 0);
        add(0, 0, 4'b0011, DB, I,  5'b00000, CA, CW, DB, 0);
        // DMA I/O write
        add(0, 1, 4'b0011, 32'h5555_5555, I,  5'b00001, KA, KW, DB, 0);
        add(0, 1, 4'b0011, 32'h5555_5555, IS, 5'b10011, KA, KW, DB, 0);
        add(0, 1, 4'b0011, 32'h5555_5555, IW, 5'b10011, KA, KW, DB, 0);
        add(0, 1, 4'b0011, 32'h5555_5555, IW, 5'b10011, KA, KW, DB, 0);
        add(0, 1, 4'b0011, 32'h5555_5555, I,  5'b00111, KA, KW, DB, 0);
        add(0, 0, 4'b0011, 32'h5555_5555, I,  5'b00001, KA, KW, DB, 0);
        // both request together: CPU, one idle cycle, then DMA
        add(1, 1, 4'b0000, R1, I,  5'b00000, CA, CW, DB, 0);
        add(1, 1, 4'b0000, R1, MS, 5'b00010, CA, CW, DB, 0);
        add(1, 1, 4'b0000, R1, MR, 5'b00010, CA, CW, DB, 0);
        add(1, 1, 4'b0000, R1, MR, 5'b00010, CA, CW, DB, 0);
        add(1, 1, 4'b0000, R1, I,  5'b01010, CA, CW, R1, 0);
        add(0, 1, 4'b0000, R2, I,  5'b00001, KA, KW, R1, 0);
        add(0, 1, 4'b0000, R2, MS, 5'b00011, KA, KW, R1, 0);
        add(0, 1, 4'b0000, R2, MR, 5'b00011, KA, KW, R1, 0);
        add(0, 1, 4'b0000, R2, MR, 5'b00011, KA, KW, R1, 0);
        add(0, 1, 4'b0000, R2, I,  5'b00111, KA, KW, R1, R2);
        add(0, 0, 4'b0000, R2, I,  5'b00001, KA, KW, R1, R2);

        repeat (3) @(negedge Clk);
        check("reset_state", obs(), {I, 5'b00000, 128'h0});
        Reset = 1'b1;
        foreach (vq[i]) begin
            c_req = vq[i].cr;
            k_req = vq[i].kr;
            {c_wr, c_io, k_wr, k_io} = vq[i].ctl;
            bus_rdata = vq[i].rd;
            @(negedge Clk);
            check($sformatf("vec%0d", i), obs(), vq[i].exp);
        end

        // both held: grants must alternate CPU, DMA, CPU, DMA
        {c_wr, c_io, k_wr, k_io} = 4'b0000;
        bus_rdata = 32'h3333_3333;
        c_req = 1'b1;
        k_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge Clk);
            if (c_done || k_done) begin
                b = n[0];
                check($sformatf("rr_done%0d", n), {136'h0, gnt, c_done, k_done}, {136'h0, b, ~b, b});
                n++;
                if (n == 4) begin
                    c_req = 1'b0;
                    k_req = 1'b0;
                end
            end
        end
        c_req = 1'b0;
        k_req = 1'b0;
        check("rr_count", 139'(n), 139'd4);
        repeat (2) @(negedge Clk);
        check("rr_idle", {136'h0, busy, c_done, k_done}, 139'h0);

        // reset asserted while the read strobe is active
        bus_rdata = 32'h7777_7777;
        c_req = 1'b1;
        repeat (3) @(negedge Clk);
        check("abort_in_strobe", {137'h0, dcs_, drd_}, 139'h0);
        #2 Reset = 1'b0;
        c_req = 1'b0;
        #1 check("abort_async", {130'h0, dcs_, drd_, dwr_, IOcs_, IOrd_, IOwr_, bus_oe, busy, c_done},
                 {130'h0, 9'b111111000});
        saw = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (c_done) saw = 1'b1;
        end
        Reset = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            if (c_done) saw = 1'b1;
        end
        check("abort_no_done", {138'h0, saw}, 139'h0);
        bus_rdata = 32'hCAFE_F00D;
        c_req = 1'b1;
        lat = -1;
        for (int i = 0; i <= 10 && lat < 0; i++) begin
            @(negedge Clk);
            if (c_done) lat = i;
        end
        c_req = 1'b0;
        check("fresh_latency", 139'(lat), 139'd4);
        check("fresh_rdata", {107'h0, c_rdata}, {107'h0, 32'hCAFE_F00D});

        // zero wait-state build
        z_rd = 32'hA5A5_A5A5;
        z_req = 1'b1;
        lat = -1;
        nrd = 0;
        ncs = 0;
        for (int i = 0; i <= 10 && lat < 0; i++) begin
            @(negedge Clk);
            if (!z_drd) nrd++;
            if (!z_dcs) ncs++;
            if (z_done) lat = i;
        end
        z_req = 1'b0;
        check("ws0_latency", 139'(lat), 139'd3);
        check("ws0_drd_cycles", 139'(nrd), 139'd1);
        check("ws0_dcs_cycles", 139'(ncs), 139'd2);
        check("ws0_rdata", {107'h0, z_rdata}, {107'h0, 32'hA5A5_A5A5});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
